sequenciador_niveis: RTL and testbench
======================================

# sequenciador_niveis

Game controller for the 8×8 LED-matrix puzzle. It sits between the physical buttons and the matrix controller.
- Converts raw button levels into single-cycle, one-at-a-time toggle pulses.
- Sequences levels 0..N_NIVEIS-1 and clears the matrix between levels.
- Counts moves, and declares overall victory or defeat.

## Interface
Parameters:
- N_NIVEIS, 5, number of levels; maximum 8.
- DEBOUNCE_CICLOS, 1000, number of consecutive stable cycles before a button level is accepted.
- MAX_JOGADAS, 63, move limit per level; must fit in 6 bits.
- CELEBRA_CICLOS, 5000, number of cycles spent in CELEBRA.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high; clock clk.
- iniciar  in  1  start/restart request, level-sensitive.
- botoes_brutos  in  8  raw, asynchronous button levels; 1 = pressed.
- nivel_concluido  in  1  win flag from the matrix controller; registered there, so it lags each toggle by 1 cycle.
- botoes_pulso  out  8  toggle command to the matrix; at most one bit high, for exactly one cycle.
- nivel  out  3  current level.
- rst_matriz  out  1  registered clear pulse to the matrix.
- jogadas  out  6  moves used in the current level.
- estado  out  3  FSM state code.
- vitoria  out  1  high while in FIM_VITORIA.
- derrota  out  1  high while in FIM_DERROTA.

## Operation
FSM states: OCIOSO=0, LIMPA=1, JOGANDO=2, CELEBRA=3, FIM_VITORIA=4, FIM_DERROTA=5.
- OCIOSO: on iniciar=1, go to LIMPA with nivel=0.
- LIMPA: lasts exactly 1 cycle. rst_matriz=1, jogadas cleared, pending buttons cleared. Then go to JOGANDO.
- JOGANDO: issue button pulses (see below). jogadas increments on each issued pulse and saturates at MAX_JOGADAS.
- Leaving JOGANDO, priority order:
  1. nivel_concluido=1 and no pulse was issued in the previous 2 cycles → CELEBRA.
  2. Otherwise, jogadas==MAX_JOGADAS and no pulse issued in the previous 2 cycles → FIM_DERROTA.
- CELEBRA: counts CELEBRA_CICLOS cycles. At the end:
  - if nivel==N_NIVEIS-1 → FIM_VITORIA;
  - otherwise nivel+1 → LIMPA.
- FIM_VITORIA / FIM_DERROTA: hold nivel and jogadas. On iniciar=1 → LIMPA with nivel=0.
- iniciar in any other state is ignored.

Button path, per bit:
- 2-flop synchronizer, then filter (see Configuration), then rising-edge detector.
- Detected edges are ORed into an 8-bit pending register.
- Each JOGANDO cycle, the lowest set pending bit is issued on botoes_pulso and cleared. Simultaneous presses therefore come out in ascending index order on consecutive cycles; none are lost.
- Edges detected outside JOGANDO are discarded.
- Holding a button issues exactly one pulse; a new pulse requires a release and a re-press.
- Once jogadas==MAX_JOGADAS, no further pulses are issued; pending bits are kept until LIMPA.

## Timing
- Reset: estado=OCIOSO, nivel=0, jogadas=0, botoes_pulso=0, rst_matriz=0, vitoria=0, derrota=0. Pending register, filters and counters are all cleared.
- rst asserted mid-game returns to OCIOSO immediately; no pulse may follow.
- All outputs are registered.
- rst_matriz is high for exactly the LIMPA cycle.
- Press latency: a raw rising edge sampled at cycle 0, with no contention, gives botoes_pulso high at cycle 4 when SEQ_DEBOUNCE_EN is undefined, and at cycle 4+DEBOUNCE_CICLOS when it is defined.
- nivel changes on the same edge that enters LIMPA. The matrix therefore sees the new level while being cleared.
- Completion guard: CELEBRA entry takes at least 3 cycles after the last pulse, so a stale nivel_concluido is never acted on.

## Configuration
- SEQ_DEBOUNCE_EN defined: each synchronized bit passes a counter filter; the output changes only after DEBOUNCE_CICLOS consecutive equal samples.
- SEQ_DEBOUNCE_EN undefined: the filter is a wire, suitable for simulation; DEBOUNCE_CICLOS is unused.

## Structure
- Package seq_pkg:
  - state encoding constants (OCIOSO..FIM_DERROTA);
  - width constants NIVEL_W=3, JOGADAS_W=6, BOTOES=8.
- Sub-module filtro_botao: synchronizer + optional debounce + edge detector for 1 bit, instantiated 8×.

## Test plan
- Reset, then iniciar=1 for 1 cycle → LIMPA for 1 cycle with rst_matriz=1, then estado=2, nivel=0.
- Raw 8'b00010010 in one cycle (SEQ_DEBOUNCE_EN undefined) → botoes_pulso=8'h02 at cycle 4, 8'h10 at cycle 5, jogadas=2.
- Button held 100 cycles → exactly one pulse. Release and press again → second pulse.
- nivel_concluido=1 at level 4 (N_NIVEIS=5) → CELEBRA for CELEBRA_CICLOS cycles, then vitoria=1, estado=4.
- MAX_JOGADAS=3: three presses without completion → jogadas=3, derrota=1 three cycles after the last pulse. A further press gives no pulse.
- rst pulsed while a pulse is pending → all outputs 0 next cycle, no pulse thereafter.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the level sequencer.
package seq_pkg;

   localparam int unsigned NIVEL_W   = 3;
   localparam int unsigned JOGADAS_W = 6;
   localparam int unsigned BOTOES    = 8;

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      LIMPA       = 3'd1,
      JOGANDO     = 3'd2,
      CELEBRA     = 3'd3,
      FIM_VITORIA = 3'd4,
      FIM_DERROTA = 3'd5
   } estado_t;

   // Isolates the lowest set bit (two's-complement trick).
   function automatic logic [BOTOES-1:0] bit_menor(input logic [BOTOES-1:0] v);
      return v & (~v + 8'd1);
   endfunction

endpackage

// File: rtl/sequenciador_niveis_if.sv
// Button/matrix-side signal bundle of the level sequencer.
interface sequenciador_niveis_if;
   import seq_pkg::*;

   logic                 iniciar;
   logic [BOTOES-1:0]    botoes_brutos;
   logic                 nivel_concluido;
   logic [BOTOES-1:0]    botoes_pulso;
   logic [NIVEL_W-1:0]   nivel;
   logic                 rst_matriz;
   logic [JOGADAS_W-1:0] jogadas;
   logic [2:0]           estado;
   logic                 vitoria;
   logic                 derrota;

   modport master (
      output iniciar, botoes_brutos, nivel_concluido,
      input  botoes_pulso, nivel, rst_matriz, jogadas, estado, vitoria, derrota
   );

   modport slave (
      input  iniciar, botoes_brutos, nivel_concluido,
      output botoes_pulso, nivel, rst_matriz, jogadas, estado, vitoria, derrota
   );

endinterface

// File: rtl/filtro_botao.sv
// One button bit: 2-flop synchronizer, optional debounce, registered rising-edge detector.
// Build option: define SEQ_DEBOUNCE_EN to enable the counter-based debounce filter.
module filtro_botao
`ifdef SEQ_DEBOUNCE_EN
#(
   parameter int unsigned DEBOUNCE_CICLOS = 1000
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic bruto,
   output logic borda
);

   logic sinc1_q, sinc2_q, filtrado, anterior_q, borda_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sinc1_q <= 1'b0;
         sinc2_q <= 1'b0;
      end else begin
         sinc1_q <= bruto;
         sinc2_q <= sinc1_q;
      end
   end

`ifdef SEQ_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CICLOS + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             estavel_q;

   // Any disagreeing sample restarts the run of equal samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         estavel_q <= 1'b0;
      end else if (sinc2_q == estavel_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
         estavel_q <= sinc2_q;
         cnt_q     <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign filtrado = estavel_q;
`else
   assign filtrado = sinc2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anterior_q <= 1'b0;
         borda_q    <= 1'b0;
      end else begin
         anterior_q <= filtrado;
         borda_q    <= filtrado & ~anterior_q;
      end
   end

   assign borda = borda_q;

endmodule

// File: rtl/sequenciador_niveis.sv
// Puzzle game controller: button pulses, level sequencing, move count, win/lose.
// Build option: define SEQ_DEBOUNCE_EN to debounce buttons over DEBOUNCE_CICLOS cycles.
module sequenciador_niveis
   import seq_pkg::*;
#(
   parameter int unsigned N_NIVEIS        = 5,
   parameter int unsigned DEBOUNCE_CICLOS = 1000,
   parameter int unsigned MAX_JOGADAS     = 63,
   parameter int unsigned CELEBRA_CICLOS  = 5000
) (
   input logic                  clk,
   input logic                  rst,
   sequenciador_niveis_if.slave bus
);

   localparam int unsigned CEL_W = $clog2(CELEBRA_CICLOS + 1);

   if (N_NIVEIS < 1 || N_NIVEIS > 8 || MAX_JOGADAS < 1 || MAX_JOGADAS > 63 ||
       DEBOUNCE_CICLOS < 1 || CELEBRA_CICLOS < 1) begin : g_param_invalido
      $error("sequenciador_niveis: parameter out of range");
   end

   logic [BOTOES-1:0] bordas;

   for (genvar i = 0; i < BOTOES; i++) begin : g_filtro
      filtro_botao
`ifdef SEQ_DEBOUNCE_EN
      #(
         .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
      )
`endif
      u_filtro (
         .clk  (clk),
         .rst  (rst),
         .bruto(bus.botoes_brutos[i]),
         .borda(bordas[i])
      );
   end

   estado_t              estado_q;
   logic [NIVEL_W-1:0]   nivel_q;
   logic [JOGADAS_W-1:0] jogadas_q;
   logic [BOTOES-1:0]    pulso_q, pend_q, menor;
   logic                 pulso_ant_q, rst_matriz_q, vitoria_q, derrota_q;
   logic [CEL_W-1:0]     cel_q;
   logic                 pronto, no_limite, conclui, esgota, emite;

   // pronto: no pulse issued in the two previous cycles, so nivel_concluido is fresh.
   always_comb begin
      menor     = bit_menor(pend_q);
      pronto    = (pulso_q == '0) && !pulso_ant_q;
      no_limite = (jogadas_q == JOGADAS_W'(MAX_JOGADAS));
      conclui   = (estado_q == JOGANDO) && bus.nivel_concluido && pronto;
      esgota    = (estado_q == JOGANDO) && no_limite && pronto;
      emite     = (estado_q == JOGANDO) && !conclui && !esgota && !no_limite && (pend_q != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else if (estado_q == LIMPA) begin
         pend_q <= '0;
      end else if (estado_q == JOGANDO) begin
         pend_q <= (pend_q & ~(emite ? menor : '0)) | bordas;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q     <= OCIOSO;
         nivel_q      <= '0;
         jogadas_q    <= '0;
         pulso_q      <= '0;
         pulso_ant_q  <= 1'b0;
         rst_matriz_q <= 1'b0;
         vitoria_q    <= 1'b0;
         derrota_q    <= 1'b0;
         cel_q        <= '0;
      end else begin
         pulso_ant_q  <= |pulso_q;
         pulso_q      <= emite ? menor : '0;
         rst_matriz_q <= 1'b0;
         unique case (estado_q)
            OCIOSO: begin
               if (bus.iniciar) begin
                  estado_q     <= LIMPA;
                  nivel_q      <= '0;
                  jogadas_q    <= '0;
                  rst_matriz_q <= 1'b1;
               end
            end
            LIMPA: estado_q <= JOGANDO;
            JOGANDO: begin
               if (conclui) begin
                  estado_q <= CELEBRA;
                  cel_q    <= '0;
               end else if (esgota) begin
                  estado_q  <= FIM_DERROTA;
                  derrota_q <= 1'b1;
               end else if (emite) begin
                  jogadas_q <= jogadas_q + 1'b1;
               end
            end
            CELEBRA: begin
               if (cel_q == CEL_W'(CELEBRA_CICLOS - 1)) begin
                  if (nivel_q == NIVEL_W'(N_NIVEIS - 1)) begin
                     estado_q  <= FIM_VITORIA;
                     vitoria_q <= 1'b1;
                  end else begin
                     estado_q     <= LIMPA;
                     nivel_q      <= nivel_q + 1'b1;
                     jogadas_q    <= '0;
                     rst_matriz_q <= 1'b1;
                  end
               end else begin
                  cel_q <= cel_q + 1'b1;
               end
            end
            FIM_VITORIA, FIM_DERROTA: begin
               if (bus.iniciar) begin
                  estado_q     <= LIMPA;
                  nivel_q      <= '0;
                  jogadas_q    <= '0;
                  rst_matriz_q <= 1'b1;
                  vitoria_q    <= 1'b0;
                  derrota_q    <= 1'b0;
               end
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign bus.botoes_pulso = pulso_q;
   assign bus.nivel        = nivel_q;
   assign bus.rst_matriz   = rst_matriz_q;
   assign bus.jogadas      = jogadas_q;
   assign bus.estado       = estado_q;
   assign bus.vitoria      = vitoria_q;
   assign bus.derrota      = derrota_q;

endmodule

// File: tb/tb_sequenciador_niveis.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops and compares them.
module tb_sequenciador_niveis;

   typedef struct packed {
      logic [7:0]  pulso;
      logic [2:0]  estado;
      logic [2:0]  nivel;
      logic [5:0]  jogadas;
      logic        rm;
      logic        vit;
      logic        der;
      logic [31:0] cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   ev_t         esperados[$];

   sequenciador_niveis_if bus ();

   sequenciador_niveis #(
      .N_NIVEIS       (5),
      .DEBOUNCE_CICLOS(1000),
      .MAX_JOGADAS    (3),
      .CELEBRA_CICLOS (20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic esperar(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic prever(input logic [7:0] p, input logic [2:0] e, input logic [2:0] n,
                         input logic [5:0] j, input logic rm, input logic v, input logic d,
                         input int unsigned c);
      ev_t x;
      x.pulso = p; x.estado = e; x.nivel = n; x.jogadas = j;
      x.rm = rm; x.vit = v; x.der = d; x.cyc = c;
      esperados.push_back(x);
   endtask

   task automatic conferir(input string nome, input logic [31:0] atual, input logic [31:0] req);
      checks++;
      if (atual !== req) begin
         failures++;
         $display("FAIL %s: atual=%0h requerido=%0h", nome, atual, req);
      end
   endtask

   task automatic iniciar_jogo();
      int unsigned c;
      c = cyc;
      bus.iniciar = 1'b1;
      prever(8'h00, 3'd1, 3'd0, 6'd0, 1'b1, 1'b0, 1'b0, c + 1);
      prever(8'h00, 3'd2, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, c + 2);
      esperar(1);
      bus.iniciar = 1'b0;
      esperar(1);
   endtask

   task automatic concluir(input logic [2:0] lvl, input logic [5:0] jog);
      int unsigned c;
      c = cyc;
      bus.nivel_concluido = 1'b1;
      prever(8'h00, 3'd3, lvl, jog, 1'b0, 1'b0, 1'b0, c + 1);
      if (lvl == 3'd4) begin
         prever(8'h00, 3'd4, lvl, jog, 1'b0, 1'b1, 1'b0, c + 21);
      end else begin
         prever(8'h00, 3'd1, lvl + 3'd1, 6'd0, 1'b1, 1'b0, 1'b0, c + 21);
         prever(8'h00, 3'd2, lvl + 3'd1, 6'd0, 1'b0, 1'b0, 1'b0, c + 22);
      end
      esperar(1);
      bus.nivel_concluido = 1'b0;
      esperar(25);
   endtask

   task automatic conferir_zeros(input string nome);
      conferir({nome, " estado"}, 32'(bus.estado), 32'd0);
      conferir({nome, " nivel"}, 32'(bus.nivel), 32'd0);
      conferir({nome, " jogadas"}, 32'(bus.jogadas), 32'd0);
      conferir({nome, " pulso"}, 32'(bus.botoes_pulso), 32'd0);
      conferir({nome, " rst_matriz"}, 32'(bus.rst_matriz), 32'd0);
      conferir({nome, " vitoria"}, 32'(bus.vitoria), 32'd0);
      conferir({nome, " derrota"}, 32'(bus.derrota), 32'd0);
   endtask

   // Monitor: every pulse or state change is an event matched against the queue.
   initial begin
      logic [2:0] estado_ant;
      ev_t        obs, exp;
      estado_ant = 3'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            estado_ant = bus.estado;
         end else if (bus.botoes_pulso != 8'h00 || bus.estado != estado_ant) begin
            obs.pulso = bus.botoes_pulso; obs.estado = bus.estado; obs.nivel = bus.nivel;
            obs.jogadas = bus.jogadas; obs.rm = bus.rst_matriz; obs.vit = bus.vitoria;
            obs.der = bus.derrota; obs.cyc = cyc;
            estado_ant = bus.estado;
            checks++;
            if (esperados.size() == 0) begin
               failures++;
               $display("FAIL evento inesperado: pulso=%h estado=%0d nivel=%0d jog=%0d ciclo=%0d",
                        obs.pulso, obs.estado, obs.nivel, obs.jogadas, obs.cyc);
            end else begin
               exp = esperados.pop_front();
               if (obs !== exp) begin
                  failures++;
                  $display({"FAIL evento: atual pulso=%h est=%0d niv=%0d jog=%0d rm=%0d v=%0d ",
                            "d=%0d ciclo=%0d; requerido pulso=%h est=%0d niv=%0d jog=%0d rm=%0d ",
                            "v=%0d d=%0d ciclo=%0d"},
                           obs.pulso, obs.estado, obs.nivel, obs.jogadas, obs.rm, obs.vit,
                           obs.der, obs.cyc, exp.pulso, exp.estado, exp.nivel, exp.jogadas,
                           exp.rm, exp.vit, exp.der, exp.cyc);
               end
            end
         end
      end
   end

   initial begin
      int unsigned c;
      bus.iniciar = 1'b0;
      bus.botoes_brutos = 8'h00;
      bus.nivel_concluido = 1'b0;
      esperar(3);
      conferir_zeros("reset");
      rst = 1'b0;
      esperar(2);

      // Level 0: two simultaneous presses come out in ascending order.
      iniciar_jogo();
      c = cyc;
      bus.botoes_brutos = 8'b0001_0010;
      prever(8'h02, 3'd2, 3'd0, 6'd1, 1'b0, 1'b0, 1'b0, c + 5);
      prever(8'h10, 3'd2, 3'd0, 6'd2, 1'b0, 1'b0, 1'b0, c + 6);
      esperar(1);
      bus.botoes_brutos = 8'h00;
      esperar(10);
      conferir("jogadas nivel0", 32'(bus.jogadas), 32'd2);
      concluir(3'd0, 6'd2);

      // Level 1: a long hold gives one pulse, a re-press gives another.
      c = cyc;
      bus.botoes_brutos = 8'h08;
      prever(8'h08, 3'd2, 3'd1, 6'd1, 1'b0, 1'b0, 1'b0, c + 5);
      esperar(100);
      bus.botoes_brutos = 8'h00;
      esperar(10);
      c = cyc;
      bus.botoes_brutos = 8'h08;
      prever(8'h08, 3'd2, 3'd1, 6'd2, 1'b0, 1'b0, 1'b0, c + 5);
      esperar(5);
      bus.botoes_brutos = 8'h00;
      esperar(10);
      concluir(3'd1, 6'd2);
      concluir(3'd2, 6'd0);
      concluir(3'd3, 6'd0);
      concluir(3'd4, 6'd0);
      conferir("vitoria", 32'(bus.vitoria), 32'd1);
      conferir("estado vitoria", 32'(bus.estado), 32'd4);

      // Restart, exhaust the move limit; the late press stays pending without a pulse.
      iniciar_jogo();
      c = cyc;
      bus.botoes_brutos = 8'h01;
      prever(8'h01, 3'd2, 3'd0, 6'd1, 1'b0, 1'b0, 1'b0, c + 5);
      prever(8'h20, 3'd2, 3'd0, 6'd2, 1'b0, 1'b0, 1'b0, c + 15);
      prever(8'h80, 3'd2, 3'd0, 6'd3, 1'b0, 1'b0, 1'b0, c + 25);
      prever(8'h00, 3'd5, 3'd0, 6'd3, 1'b0, 1'b0, 1'b1, c + 28);
      esperar(3);
      bus.botoes_brutos = 8'h00;
      esperar(7);
      bus.botoes_brutos = 8'h20;
      esperar(3);
      bus.botoes_brutos = 8'h00;
      esperar(7);
      bus.botoes_brutos = 8'h80;
      esperar(1);
      bus.botoes_brutos = 8'h00;
      esperar(1);
      bus.botoes_brutos = 8'h40;
      esperar(3);
      bus.botoes_brutos = 8'h00;
      esperar(10);
      conferir("derrota", 32'(bus.derrota), 32'd1);
      conferir("jogadas derrota", 32'(bus.jogadas), 32'd3);

      // Restart clears the stale pending bit; reset lands while a new press is pending.
      iniciar_jogo();
      c = cyc;
      bus.botoes_brutos = 8'h02;
      esperar(2);
      bus.botoes_brutos = 8'h00;
      esperar(2);
      rst = 1'b1;
      #1;
      conferir_zeros("rst no jogo");
      @(negedge clk);
      rst = 1'b0;
      esperar(20);
      conferir("estado final", 32'(bus.estado), 32'd0);
      conferir("fila vazia", 32'(esperados.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
